f3m_addsub_serial: RTL and testbench

//   Digit-serial GF(3^M) add/subtract engine. Takes two packed GF(3^M) elements and combines

---
 rtl/f3m_addsub_serial_if.sv | 33 +++
 rtl/f3m_addsub_serial.sv | 171 +++++++++++++++++
 tb/tb_f3m_addsub_serial.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/f3m_addsub_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : f3m_addsub_serial_if
//  Description : Handshake and operand/result bundle for the digit-serial
//                GF(3^M) add/subtract engine.
//                master : start, op, A, B  ->  slave
//                slave  : busy, done, C, err ->  master
//                Each element is 2*M bits wide, with two bits per GF(3) digit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface f3m_addsub_serial_if #(
    parameter int M = 593
);
    logic           start;
    logic           op;
    logic [2*M-1:0] A;
    logic [2*M-1:0] B;
    logic           busy;
    logic           done;
    logic [2*M-1:0] C;
    logic           err;

    modport master (
        output start, op, A, B,
        input  busy, done, C, err
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, C, err
    );
endinterface
`default_nettype wire

// File: rtl/f3m_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : f3m_addsub_serial
//  Description : Digit-serial GF(3^M) adder/subtractor. Each RUN cycle handles
//                DIGITS_PER_CYCLE digits. The result is loaded into C in one
//                step, on the cycle that done pulses.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-low reset
//                bus    - slave side of the interface: start/op/A/B in,
//                         busy/done/C/err out
//  Options     : F3M_ADDSUB_ILLEGAL_CHECK_EN - when defined, digits encoded
//                as 2'b11 set the sticky err flag. When undefined, err is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module f3m_addsub_serial #(
    parameter int M                = 593,
    parameter int DIGITS_PER_CYCLE = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    f3m_addsub_serial_if.slave bus
);
    localparam int D  = DIGITS_PER_CYCLE;
    localparam int N  = (M + D - 1) / D;   // RUN cycles per operation
    localparam int CW = $clog2(N) + 1;
    localparam int GW = 2 * D;             // bits per digit group
    localparam int PW = GW * N;            // padded operand width

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  a_sh_q, a_sh_d;
    logic [PW-1:0]  b_sh_q, b_sh_d;
    logic [PW-1:0]  acc_q,  acc_d;
    logic           op_q,   op_d;
    logic [CW-1:0]  cnt_q,  cnt_d;
    logic           done_q, done_d;
    logic [2*M-1:0] c_q,    c_d;
    logic [GW-1:0]  grp_w;

    // GF(3) addition of two legal digits. Illegal codes map to 0.
    function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        case ({a, b})
            4'b00_00: r = 2'd0;
            4'b00_01: r = 2'd1;
            4'b00_10: r = 2'd2;
            4'b01_00: r = 2'd1;
            4'b01_01: r = 2'd2;
            4'b01_10: r = 2'd0;
            4'b10_00: r = 2'd2;
            4'b10_01: r = 2'd0;
            4'b10_10: r = 2'd1;
            default:  r = 2'd0;
        endcase
        return r;
    endfunction

    // Compute the current digit group, taken from the low end of the shifters.
    // Negating in GF(3) swaps 1 and 2, which is a swap of the two code bits.
    always_comb begin
        grp_w = '0;
        for (int i = 0; i < D; i++) begin
            logic [1:0] bd;
            bd = b_sh_q[2*i +: 2];
            if (op_q) bd = {bd[0], bd[1]};
            grp_w[2*i +: 2] = f3_add(a_sh_q[2*i +: 2], bd);
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Zero-extend to a whole number of groups. Padding digits
                    // are legal zeros and are never copied into C.
                    a_sh_d          = '0;
                    a_sh_d[2*M-1:0] = bus.A;
                    b_sh_d          = '0;
                    b_sh_d[2*M-1:0] = bus.B;
                    op_d            = bus.op;
                    cnt_d           = '0;
                    state_d         = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> GW;
                b_sh_d = b_sh_q >> GW;
                // The result shifts in from the top. After N steps, group 0
                // has reached bit 0.
                acc_d            = acc_q >> GW;
                acc_d[PW-1 -: GW] = grp_w;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    c_d     = acc_d[2*M-1:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            c_q     <= c_d;
        end
    end

`ifdef F3M_ADDSUB_ILLEGAL_CHECK_EN
    // Every real digit passes through the group window exactly once.
    // Padding is zero, so only real digits can raise the flag.
    logic err_q, err_d;
    logic grp_bad_w;

    always_comb begin
        grp_bad_w = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (a_sh_q[2*i +: 2] == 2'b11 || b_sh_q[2*i +: 2] == 2'b11)
                grp_bad_w = 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && bus.start) err_d = 1'b0;
        else if (state_q == ST_RUN)          err_d = err_q | grp_bad_w;
    end

    always_ff @(posedge clk) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
    assign bus.C    = c_q;
endmodule
`default_nettype wire

// File: tb/tb_f3m_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f3m_addsub_serial
//  Description : Directed self-checking bench. One instance uses M=5, D=2
//                (N=3) and another uses the default parameters (N=75).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_f3m_addsub_serial;
    localparam int MS = 5;
    localparam int MB = 593;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    f3m_addsub_serial_if #(.M(MS)) sif ();
    f3m_addsub_serial_if #(.M(MB)) bif ();

    f3m_addsub_serial #(.M(MS), .DIGITS_PER_CYCLE(2)) dut_s (
        .clk(clk), .reset(rst_n), .bus(sif)
    );
    f3m_addsub_serial #(.M(MB), .DIGITS_PER_CYCLE(8)) dut_b (
        .clk(clk), .reset(rst_n), .bus(bif)
    );

`ifdef F3M_ADDSUB_ILLEGAL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    // The task begins #1 after a rising edge. It returns #1 after the done
    // edge (lat = 0 means done never arrived).
    task automatic op_s(input logic [9:0] a, input logic [9:0] b, input logic o,
                        output logic [9:0] c, output int lat, output int busy_n,
                        output logic e);
        sif.A = a; sif.B = b; sif.op = o; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        lat = 0; busy_n = sif.busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (sif.done) begin lat = k; break; end
            if (sif.busy) busy_n++;
        end
        c = sif.C; e = sif.err;
    endtask

    task automatic op_b(input logic [2*MB-1:0] a, input logic [2*MB-1:0] b, input logic o,
                        output logic [2*MB-1:0] c, output int lat);
        bif.A = a; bif.B = b; bif.op = o; bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (bif.done) begin lat = k; break; end
        end
        c = bif.C;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sif.start = 0; sif.op = 0; sif.A = '0; sif.B = '0;
        bif.start = 0; bif.op = 0; bif.A = '0; bif.B = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({sif.busy, sif.done, sif.err} !== 3'b000 || sif.C !== 10'h0) begin
            bad++;
            $display("FAIL reset_small: busy=%b done=%b err=%b C=%h required 0 0 0 000",
                     sif.busy, sif.done, sif.err, sif.C);
        end
        total++;
        if ({bif.busy, bif.done, bif.err} !== 3'b000 || bif.C !== '0) begin
            bad++;
            $display("FAIL reset_big: busy=%b done=%b err=%b C nonzero=%b required all 0",
                     bif.busy, bif.done, bif.err, |bif.C);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [9:0] c; int lat, bn; logic e;
        op_s(10'h249, 10'h168, 1'b0, c, lat, bn, e);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL add_latency: got %0d required 3", lat); end
        total++;
        if (bn !== 3) begin bad++; $display("FAIL add_busy_cycles: got %0d required 3", bn); end
        total++;
        if (c !== 10'h0A5) begin bad++; $display("FAIL add_result: C=%h required 0a5", c); end
        total++;
        if (sif.busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done: busy=%b required 0", sif.busy); end
        @(posedge clk); #1;
        total++;
        if (sif.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: done=%b required 0", sif.done); end
        total++;
        if (sif.C !== 10'h0A5) begin bad++; $display("FAIL c_hold: C=%h required 0a5", sif.C); end
    endtask

    task automatic test_sub;
        logic [9:0] c; int lat, bn; logic e;
        op_s(10'h249, 10'h168, 1'b1, c, lat, bn, e);
        total++;
        if (c !== 10'h111 || lat !== 3) begin
            bad++; $display("FAIL sub_result: C=%h lat=%0d required 111 lat=3", c, lat);
        end
        op_s(10'h249, 10'h249, 1'b1, c, lat, bn, e);
        total++;
        if (c !== 10'h000) begin bad++; $display("FAIL sub_self: C=%h required 000", c); end
        // Both zero fields and the top digit: 2-1=1 in digit 4, 0-2=1 in digit 0
        op_s(10'h200, 10'h102, 1'b1, c, lat, bn, e);
        total++;
        if (c !== 10'h101) begin bad++; $display("FAIL sub_mixed: C=%h required 101", c); end
    endtask

    task automatic test_defaults;
        logic [2*MB-1:0] ones, twos, c; int lat;
        ones = {MB{2'b01}};
        twos = {MB{2'b10}};
        op_b(ones, twos, 1'b1, c, lat);
        total++;
        if (lat !== 75) begin bad++; $display("FAIL big_latency_sub: got %0d required 75", lat); end
        total++;
        if (c !== twos) begin bad++; $display("FAIL big_sub: C low=%h required all digits 2", c[31:0]); end
        op_b(ones, twos, 1'b0, c, lat);
        total++;
        if (lat !== 75 || c !== '0) begin
            bad++; $display("FAIL big_add: lat=%0d C low=%h required 75 and 0", lat, c[31:0]);
        end
    endtask

    task automatic test_start_in_run;
        int lat; int extra;
        sif.A = 10'h249; sif.B = 10'h168; sif.op = 1'b0; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #1;
        sif.A = 10'h155; sif.B = 10'h2AA; sif.op = 1'b1; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        lat = 0;
        for (int k = 3; k <= 20; k++) begin
            if (sif.done) begin lat = k - 1; break; end
            @(posedge clk); #1;
        end
        total++;
        if (lat !== 3 || sif.C !== 10'h0A5) begin
            bad++; $display("FAIL start_in_run_ignored: lat=%0d C=%h required 3 0a5", lat, sif.C);
        end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (sif.done || sif.busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL start_not_queued: activity=%0d required 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] c; int lat, bn; logic e;
        op_s(10'h249, 10'h168, 1'b0, c, lat, bn, e);
        total++;
        if (sif.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: done=%b required 1", sif.done); end
        op_s(10'h249, 10'h168, 1'b1, c, lat, bn, e);
        total++;
        if (lat !== 3 || c !== 10'h111) begin
            bad++; $display("FAIL b2b_second: lat=%0d C=%h required 3 111", lat, c);
        end
    endtask

    task automatic test_reset_in_run;
        logic [9:0] c; int lat, bn, seen; logic e;
        sif.A = 10'h249; sif.B = 10'h249; sif.op = 1'b0; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if (sif.busy !== 1'b0 || sif.C !== 10'h000 || sif.done !== 1'b0) begin
            bad++; $display("FAIL reset_in_run: busy=%b done=%b C=%h required 0 0 000",
                            sif.busy, sif.done, sif.C);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (sif.done) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_no_done: pulses=%0d required 0", seen); end
        op_s(10'h249, 10'h168, 1'b0, c, lat, bn, e);
        total++;
        if (lat !== 3 || c !== 10'h0A5) begin
            bad++; $display("FAIL after_reset_op: lat=%0d C=%h required 3 0a5", lat, c);
        end
    endtask

    task automatic test_illegal;
        logic [9:0] c; int lat, bn; logic e;
        op_s(10'h24B, 10'h168, 1'b0, c, lat, bn, e);
        total++;
        if (e !== ERR_EXP) begin bad++; $display("FAIL err_digit0: err=%b required %b", e, ERR_EXP); end
        op_s(10'h249, 10'h168, 1'b0, c, lat, bn, e);
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL err_cleared: err=%b required 0", e); end
        op_s(10'h049, 10'h368, 1'b1, c, lat, bn, e);
        total++;
        if (e !== ERR_EXP) begin bad++; $display("FAIL err_top_digit_b: err=%b required %b", e, ERR_EXP); end
        @(posedge clk); #1;
        total++;
        if (sif.err !== ERR_EXP) begin bad++; $display("FAIL err_hold: err=%b required %b", sif.err, ERR_EXP); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_defaults();
        test_start_in_run();
        test_back_to_back();
        test_reset_in_run();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
